// File: rtl/if_pkg.sv
// if_pkg: shared fetch-state encoding and constants for the instruction fetch stage
package if_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DROP} fetch_state_t;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;
endpackage

// File: rtl/ifid_skid.sv
// ifid_skid: one-entry buffer holding a fetched word that arrived while decode was stalled
module ifid_skid
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_drain,
  input  logic        i_clear,
  input  logic [31:0] i_data,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  output logic [31:0] o_data,
  output logic [31:0] o_pc
);
  logic        r_valid;
  logic [31:0] r_data;
  logic [31:0] r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= NOP;
      r_pc    <= 32'h0;
    end else begin
      r_valid <= i_clear ? 1'b0 : i_load ? 1'b1 : i_drain ? 1'b0 : r_valid;
      if (i_load && !i_clear) begin
        r_data <= i_data;
        r_pc   <= i_pc;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_pc    = r_pc;
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch with one outstanding memory request, IF/ID register and stall skid
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_code,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4
);
  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_pc, r_fetch_pc;
  logic         r_ifid_valid;
  logic [31:0]  r_ifid_code, r_ifid_pc;
  logic         w_rsp, w_req, w_hs;
  logic         w_skid_v;
  logic [31:0]  w_skid_data, w_skid_pc;

  // A response only counts in WAIT; DROP responses belong to a redirected-away fetch
  assign w_rsp = (r_state == WAIT) && imem_rsp_valid;

  always_comb begin
    w_req = rst_n && !w_skid_v && !redirect_valid && ((r_state == IDLE) || (w_rsp && !stall));
    w_hs  = w_req && imem_req_ready;
    w_state_nxt = (r_state == IDLE) ? (w_hs ? WAIT : IDLE)
                : (r_state == WAIT) ? (imem_rsp_valid ? (w_hs ? WAIT : IDLE)
                                                      : (redirect_valid ? DROP : WAIT))
                : (imem_rsp_valid ? IDLE : DROP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_fetch_pc <= RESET_PC;
    end else begin
      if (redirect_valid) r_pc <= redirect_pc;
      else if (w_hs)      r_pc <= r_pc + 32'd4;
      if (w_hs) r_fetch_pc <= r_pc;
    end
  end

  ifid_skid u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_rsp && stall && !redirect_valid),
    .i_drain (!stall),
    .i_clear (redirect_valid),
    .i_data  (imem_rsp_data),
    .i_pc    (r_fetch_pc),
    .o_valid (w_skid_v),
    .o_data  (w_skid_data),
    .o_pc    (w_skid_pc)
  );

  // The skid is always older than any fresh response, so it drains first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ifid_valid <= 1'b0;
      r_ifid_code  <= NOP;
      r_ifid_pc    <= 32'h0;
    end else if (redirect_valid) begin
      r_ifid_valid <= 1'b0;
    end else if (!stall) begin
      if (w_skid_v) begin
        r_ifid_valid <= 1'b1;
        r_ifid_code  <= w_skid_data;
        r_ifid_pc    <= w_skid_pc;
      end else if (w_rsp) begin
        r_ifid_valid <= 1'b1;
        r_ifid_code  <= imem_rsp_data;
        r_ifid_pc    <= r_fetch_pc;
      end else begin
        r_ifid_valid <= 1'b0;
      end
    end
  end

  assign imem_req_valid = w_req;
  assign imem_req_addr  = r_pc;
  assign ifid_valid     = r_ifid_valid;
  assign ifid_code      = r_ifid_code;
  assign ifid_pc        = r_ifid_pc;
  assign ifid_pc_plus4  = r_ifid_pc + 32'd4;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed checks of fetch latency, stall skid, redirect, backpressure, wrap and reset
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_code, ifid_pc, ifid_pc_plus4;
  logic        hold;
  logic        pend_v = 1'b0;
  logic [31:0] pend_a = 32'h0;
  int          errors = 0;
  int          checks = 0;

  if_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ifid_valid(ifid_valid), .ifid_code(ifid_code), .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4)
  );

  always #5 clk = ~clk;

  // Memory: answers the next cycle unless hold is set; word 0 is a load, others are addr+0x1000_0000
  assign imem_rsp_valid = pend_v && !hold;
  assign imem_rsp_data  = (pend_a == 32'h0) ? 32'h8C01_0004 : pend_a + 32'h1000_0000;
  always @(posedge clk) begin
    if (imem_req_valid && imem_req_ready) begin
      pend_v <= 1'b1;
      pend_a <= imem_req_addr;
    end else if (imem_rsp_valid) begin
      pend_v <= 1'b0;
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; imem_req_ready = 1'b1; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; hold = 1'b0;
    tick; tick;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
    checks++; if ({ifid_valid, ifid_code, ifid_pc} !== 65'h0) begin errors++; $display("FAIL rst_ifid: got %b %h %h want 0 0 0", ifid_valid, ifid_code, ifid_pc); end
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", imem_req_addr); end
    rst_n = 1'b1;
    tick;
    checks++; if (imem_req_addr !== 32'h4) begin errors++; $display("FAIL first_req_addr: got %h want 4", imem_req_addr); end
    tick;
    checks++; if ({ifid_valid, ifid_code, ifid_pc} !== {1'b1, 32'h8C01_0004, 32'h0}) begin errors++; $display("FAIL first_ifid: got %b %h %h want 1 8c010004 0", ifid_valid, ifid_code, ifid_pc); end
    checks++; if (ifid_pc_plus4 !== 32'h4) begin errors++; $display("FAIL first_plus4: got %h want 4", ifid_pc_plus4); end
  endtask

  task automatic test_stream;
    tick;
    checks++; if ({ifid_valid, ifid_code, ifid_pc} !== {1'b1, 32'h1000_0004, 32'h4}) begin errors++; $display("FAIL stream_4: got %b %h %h", ifid_valid, ifid_code, ifid_pc); end
    tick;
    checks++; if ({ifid_valid, ifid_code, ifid_pc} !== {1'b1, 32'h1000_0008, 32'h8}) begin errors++; $display("FAIL stream_8: got %b %h %h", ifid_valid, ifid_code, ifid_pc); end
  endtask

  task automatic test_stall;
    stall = 1'b1;
    tick;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_valid: got %b want 0", imem_req_valid); end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick;
      checks++; if ({ifid_valid, ifid_code, ifid_pc} !== {1'b1, 32'h1000_0008, 32'h8}) begin errors++; $display("FAIL stall_hold%0d: got %b %h %h want 1 10000008 8", i, ifid_valid, ifid_code, ifid_pc); end
    end
    stall = 1'b0;
    tick;
    checks++; if ({ifid_valid, ifid_code, ifid_pc} !== {1'b1, 32'h1000_000C, 32'hC}) begin errors++; $display("FAIL stall_skid_out: got %b %h %h want 1 1000000c c", ifid_valid, ifid_code, ifid_pc); end
    tick;
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL stall_bubble: got %b want 0", ifid_valid); end
    tick;
    checks++; if ({ifid_valid, ifid_code, ifid_pc} !== {1'b1, 32'h1000_0010, 32'h10}) begin errors++; $display("FAIL stall_next: got %b %h %h want 1 10000010 10", ifid_valid, ifid_code, ifid_pc); end
    tick;
    checks++; if ({ifid_valid, ifid_pc} !== {1'b1, 32'h14}) begin errors++; $display("FAIL stall_resume: got %b %h want 1 14", ifid_valid, ifid_pc); end
  endtask

  task automatic test_redirect;
    hold = 1'b1;
    tick;
    checks++; if ({ifid_valid, imem_req_valid} !== 2'b00) begin errors++; $display("FAIL wait_idle: got %b%b want 00", ifid_valid, imem_req_valid); end
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick;
    checks++; if ({imem_req_valid, imem_req_addr} !== {1'b0, 32'h100}) begin errors++; $display("FAIL redir_pc: got %b %h want 0 100", imem_req_valid, imem_req_addr); end
    redirect_valid = 1'b0; hold = 1'b0;
    tick;
    checks++; if ({ifid_valid, imem_req_valid} !== 2'b01) begin errors++; $display("FAIL redir_drop: got %b%b want 01", ifid_valid, imem_req_valid); end
    tick;
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL redir_stale: got %b want 0", ifid_valid); end
    tick;
    checks++; if ({ifid_valid, ifid_code, ifid_pc} !== {1'b1, 32'h1000_0100, 32'h100}) begin errors++; $display("FAIL redir_target: got %b %h %h want 1 10000100 100", ifid_valid, ifid_code, ifid_pc); end
    tick;
    checks++; if ({ifid_valid, ifid_pc} !== {1'b1, 32'h104}) begin errors++; $display("FAIL redir_next: got %b %h want 1 104", ifid_valid, ifid_pc); end
  endtask

  task automatic test_ready_low;
    imem_req_ready = 1'b0;
    tick;
    checks++; if ({ifid_valid, ifid_pc} !== {1'b1, 32'h108}) begin errors++; $display("FAIL rdy_last: got %b %h want 1 108", ifid_valid, ifid_pc); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick;
      checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h10C}) begin errors++; $display("FAIL rdy_hold%0d: got %b %h want 1 10c", i, imem_req_valid, imem_req_addr); end
    end
    imem_req_ready = 1'b1;
    tick;
    checks++; if (imem_req_addr !== 32'h110) begin errors++; $display("FAIL rdy_advance: got %h want 110", imem_req_addr); end
    tick;
    checks++; if ({ifid_valid, ifid_code, ifid_pc} !== {1'b1, 32'h1000_010C, 32'h10C}) begin errors++; $display("FAIL rdy_word: got %b %h %h want 1 1000010c 10c", ifid_valid, ifid_code, ifid_pc); end
  endtask

  task automatic test_wrap;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick;
    checks++; if ({ifid_valid, imem_req_addr} !== {1'b0, 32'hFFFF_FFFC}) begin errors++; $display("FAIL wrap_redir: got %b %h want 0 fffffffc", ifid_valid, imem_req_addr); end
    redirect_valid = 1'b0;
    tick;
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want 0", imem_req_addr); end
    tick;
    checks++; if ({ifid_valid, ifid_code, ifid_pc, ifid_pc_plus4} !== {1'b1, 32'h0FFF_FFFC, 32'hFFFF_FFFC, 32'h0}) begin errors++; $display("FAIL wrap_ifid: got %b %h %h %h want 1 0ffffffc fffffffc 0", ifid_valid, ifid_code, ifid_pc, ifid_pc_plus4); end
    tick;
    checks++; if ({ifid_valid, ifid_code, ifid_pc} !== {1'b1, 32'h8C01_0004, 32'h0}) begin errors++; $display("FAIL wrap_zero: got %b %h %h want 1 8c010004 0", ifid_valid, ifid_code, ifid_pc); end
  endtask

  task automatic test_reset_mid_wait;
    stall = 1'b1; hold = 1'b1;
    tick;
    checks++; if ({ifid_valid, ifid_pc, imem_req_valid} !== {1'b1, 32'h0, 1'b0}) begin errors++; $display("FAIL mid_pre: got %b %h %b want 1 0 0", ifid_valid, ifid_pc, imem_req_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({ifid_valid, ifid_code, ifid_pc} !== 65'h0) begin errors++; $display("FAIL mid_async: got %b %h %h want 0 0 0", ifid_valid, ifid_code, ifid_pc); end
    checks++; if ({imem_req_valid, imem_req_addr} !== {1'b0, 32'h0}) begin errors++; $display("FAIL mid_req: got %b %h want 0 0", imem_req_valid, imem_req_addr); end
    stall = 1'b0;
    tick; tick;
    rst_n = 1'b1; hold = 1'b0;
    tick;
    checks++; if ({ifid_valid, imem_req_addr} !== {1'b0, 32'h4}) begin errors++; $display("FAIL mid_late_rsp: got %b %h want 0 4", ifid_valid, imem_req_addr); end
    tick;
    checks++; if ({ifid_valid, ifid_code, ifid_pc} !== {1'b1, 32'h8C01_0004, 32'h0}) begin errors++; $display("FAIL mid_refetch: got %b %h %h want 1 8c010004 0", ifid_valid, ifid_code, ifid_pc); end
    tick;
    checks++; if ({ifid_valid, ifid_code, ifid_pc} !== {1'b1, 32'h1000_0004, 32'h4}) begin errors++; $display("FAIL mid_next: got %b %h %h want 1 10000004 4", ifid_valid, ifid_code, ifid_pc); end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_redirect;
    test_ready_low;
    test_wrap;
    test_reset_mid_wait;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the single clock of the block.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-005 SHALL have port imem_req_ready  input  1  instruction memory accepts request.
REQ-006 SHALL have port imem_req_addr  output  32  fetch byte address, equal to the current PC.
REQ-007 SHALL have port imem_rsp_valid  input  1  instruction word returned, for the oldest outstanding request.
REQ-008 SHALL have port imem_rsp_data  input  32  returned instruction word.
REQ-009 SHALL have port stall  input  1  hazard hold; IF/ID contents must not change.
REQ-010 SHALL have port redirect_valid  input  1  jump/branch taken; refetch from redirect_pc.
REQ-011 SHALL have port redirect_pc  input  32  redirect target, word-aligned.
REQ-012 SHALL have port ifid_valid  output  1  IF/ID holds a live instruction.
REQ-013 SHALL have port ifid_code  output  32  IF/ID instruction word, consumed by decode.
REQ-014 SHALL have port ifid_pc  output  32  address of ifid_code.
REQ-015 SHALL have port ifid_pc_plus4  output  32  ifid_pc + 4, modulo 2^32.

Function
REQ-016 SHALL keep at most one memory request outstanding, tracked by FSM states IDLE, WAIT, DROP.
REQ-017 SHALL drive imem_req_valid = (IDLE, or WAIT with imem_rsp_valid, stall=0 and skid empty) AND skid empty AND redirect_valid=0.
REQ-018 SHALL complete a handshake when imem_req_valid and imem_req_ready are both high, and then set PC <= PC+4, wrapping 32'hFFFF_FFFC to 0.
REQ-019 SHALL hold imem_req_addr stable while imem_req_valid=1 and imem_req_ready=0.
REQ-020 SHALL make these FSM transitions: IDLE->WAIT on handshake; WAIT->IDLE on response without handshake; WAIT->WAIT on response with handshake; DROP->IDLE on response.
REQ-021 SHALL, in WAIT on a response with stall=0 and skid empty, load IF/ID with {1, imem_rsp_data, fetch PC}.
REQ-022 SHALL, in WAIT on a response with stall=1, capture the word and its PC into a one-entry skid buffer.
REQ-023 SHALL, when stall=0 and the skid is full, load IF/ID from the skid and empty the skid in the same cycle.
REQ-024 SHALL clear ifid_valid when stall=0 and no new instruction is loaded (bubble).
REQ-025 SHALL hold ifid_valid, ifid_code and ifid_pc unchanged while stall=1.
REQ-026 SHALL give redirect_valid priority over stall and responses: PC <= redirect_pc, ifid_valid <= 0, skid emptied.
REQ-027 SHALL, on redirect in WAIT, go to DROP, or to IDLE if the response arrives in the same cycle; that response is discarded.
REQ-028 SHALL, on redirect in DROP, go to IDLE if the response arrives in the same cycle, else stay in DROP.
REQ-029 SHALL, on redirect in IDLE, stay in IDLE.
REQ-030 SHALL never write a discarded or DROP-state response into IF/ID or the skid.
REQ-031 SHALL give latency, with a single-cycle memory and no stall: request in cycle N, response in N+1, ifid_valid=1 after edge N+1.
REQ-032 SHALL sustain one instruction per cycle in steady state.

Reset
REQ-033 SHALL, while rst_n=0, asynchronously set PC=RESET_PC, state IDLE, skid empty, ifid_valid=0, ifid_code=0, ifid_pc=0.
REQ-034 SHALL hold imem_req_valid=0 while rst_n=0 and issue the first request in the first cycle after release.
REQ-035 SHALL, on reset mid-operation, leave nothing pending: any response arriving in the first cycle after release is ignored.

Structure
REQ-036 SHALL put the FSM state enum, RESET_PC default and the NOP encoding 32'h0000_0000 in shared package if_pkg.
REQ-037 SHALL implement the skid buffer as sub-module ifid_skid (valid, data, pc; load/drain).

Verification
REQ-038 SHALL cover: reset release with ready=1 and a 1-cycle memory returning 32'h8C01_0004 -> ifid_valid=1, ifid_code=32'h8C01_0004, ifid_pc=0, ifid_pc_plus4=4.
REQ-039 SHALL cover: stall=1 for 3 cycles mid-stream -> IF/ID held; skid holds next word; after stall drops, words appear in order without loss or duplication.
REQ-040 SHALL cover: redirect to 32'h0000_0100 while in WAIT -> pending response discarded; next ifid_pc=32'h100 and no stale word appears.
REQ-041 SHALL cover: imem_req_ready=0 for 4 cycles -> imem_req_addr stable and PC not advanced.
REQ-042 SHALL cover: PC=32'hFFFF_FFFC fetched -> next imem_req_addr=0, ifid_pc_plus4=0.
REQ-043 SHALL cover: rst_n asserted while in WAIT -> outputs reset immediately; late response ignored; refetch starts at RESET_PC.
